// File: rtl/alu_pipe_pkg.sv
// Shared types, defaults and the ALU function for alu_pipe.
// alu_compute works on MAX_W-wide values masked down to the caller's width w.
package alu_pipe_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned PIPE_DEPTH_DEF = 2;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned MAX_W          = 32;
  localparam int unsigned SUM_W          = MAX_W + 1;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_MUL  = 4'd2,  OP_SHR  = 4'd3,
    OP_SHL  = 4'd4,  OP_ROR  = 4'd5,  OP_ROL  = 4'd6,  OP_NOT  = 4'd7,
    OP_AND  = 4'd8,  OP_OR   = 4'd9,  OP_XOR  = 4'd10, OP_NAND = 4'd11,
    OP_NOR  = 4'd12, OP_XNOR = 4'd13, OP_INC  = 4'd14, OP_DEC  = 4'd15
  } op_t;

  typedef enum logic [1:0] {
    MOVI_REG_B = 2'd0, MOVI_MEM = 2'd1, MOVI_IMM = 2'd2, MOVI_RSV = 2'd3
  } movi_t;

  typedef struct packed {
    logic [MAX_W-1:0] data;
    logic             carry;
  } result_t;

  function automatic result_t alu_compute(op_t op, logic [MAX_W-1:0] a_in,
                                          logic [MAX_W-1:0] b_in, int unsigned w);
    logic [MAX_W-1:0]   msk;
    logic [MAX_W-1:0]   a;
    logic [MAX_W-1:0]   b;
    logic [SUM_W-1:0]   sum;
    logic [2*MAX_W-1:0] prod;
    result_t            r;
    msk  = MAX_W'((64'(1) << w) - 64'(1));
    a    = a_in & msk;
    b    = b_in & msk;
    sum  = '0;
    prod = '0;
    r    = '0;
    // Carry/borrow is bit w of the widened sum; operands are pre-masked to w bits.
    case (op)
      OP_ADD:  begin sum = {1'b0, a} + {1'b0, b}; r.data = sum[MAX_W-1:0]; r.carry = 1'(sum >> w); end
      OP_SUB:  begin sum = {1'b0, a} - {1'b0, b}; r.data = sum[MAX_W-1:0]; r.carry = 1'(sum >> w); end
      OP_MUL:  begin
        prod    = {{MAX_W{1'b0}}, a} * {{MAX_W{1'b0}}, b};
        r.data  = prod[MAX_W-1:0];
        r.carry = |(prod >> w);
      end
      OP_SHR:  begin r.data = a >> 1; r.carry = a[0]; end
      OP_SHL:  begin r.data = a << 1; r.carry = 1'(a >> (w - 1)); end
      OP_ROR:  r.data = (a >> 1) | (MAX_W'(a[0]) << (w - 1));
      OP_ROL:  r.data = (a << 1) | MAX_W'(1'(a >> (w - 1)));
      OP_NOT:  r.data = ~a;
      OP_AND:  r.data = a & b;
      OP_OR:   r.data = a | b;
      OP_XOR:  r.data = a ^ b;
      OP_NAND: r.data = ~(a & b);
      OP_NOR:  r.data = ~(a | b);
      OP_XNOR: r.data = ~(a ^ b);
      OP_INC:  begin sum = {1'b0, a} + SUM_W'(1); r.data = sum[MAX_W-1:0]; r.carry = 1'(sum >> w); end
      OP_DEC:  begin sum = {1'b0, a} - SUM_W'(1); r.data = sum[MAX_W-1:0]; r.carry = 1'(sum >> w); end
    endcase
    r.data = r.data & msk;
    return r;
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Request/response bus of alu_pipe: issue handshake in, buffered result out.
interface alu_pipe_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  ACT;
  logic                  ALU_RDY;
  logic [3:0]            OP;
  logic [1:0]            MOVI;
  logic [DATA_WIDTH-1:0] REG_A;
  logic [DATA_WIDTH-1:0] REG_B;
  logic [DATA_WIDTH-1:0] MEM;
  logic [DATA_WIDTH-1:0] IMM;
  logic                  OUT_RDY;
  logic [DATA_WIDTH-1:0] EX_ALU;
  logic                  EX_ALU_C;
  logic                  EX_ALU_VLD;

  modport slave (
    input  ACT, OP, MOVI, REG_A, REG_B, MEM, IMM, OUT_RDY,
    output ALU_RDY, EX_ALU, EX_ALU_C, EX_ALU_VLD
  );

  modport master (
    output ACT, OP, MOVI, REG_A, REG_B, MEM, IMM, OUT_RDY,
    input  ALU_RDY, EX_ALU, EX_ALU_C, EX_ALU_VLD
  );
endinterface

// File: rtl/alu_pipe_fifo.sv
// Show-ahead FIFO with wrapping pointers and a separate occupancy count.
// Head data reads as zero while empty.
module alu_pipe_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: stage 1 samples the request, later stages delay the result,
// and a credit counter throttles ALU_RDY so the output FIFO cannot overflow.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned PIPE_DEPTH = PIPE_DEPTH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  alu_pipe_if.slave  bus
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW = DATA_WIDTH + 1;

  logic                  rdy_q, rdy_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  acc, pop;
  logic                  v1_q;
  op_t                   op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, b_sel;
  result_t               res;
  logic [EW-1:0]         s1_ent, fifo_wdata, fifo_rdata;
  logic                  fifo_push, fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;

  // Handshake, operand select and credit update.
  always_comb begin
    acc   = bus.ACT && rdy_q;
    pop   = bus.OUT_RDY && !fifo_empty;
    cnt_d = cnt_q;
    if (acc && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !acc) cnt_d = cnt_q - CW'(1);
    rdy_d = (cnt_d < CW'(FIFO_DEPTH));
    case (movi_t'(bus.MOVI))
      MOVI_REG_B: b_sel = bus.REG_B;
      MOVI_MEM:   b_sel = bus.MEM;
      default:    b_sel = bus.IMM;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rdy_q <= 1'b0;
      cnt_q <= '0;
      v1_q  <= 1'b0;
      op_q  <= OP_ADD;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      rdy_q <= rdy_d;
      cnt_q <= cnt_d;
      v1_q  <= acc;
      if (acc) begin
        op_q <= op_t'(bus.OP);
        a_q  <= bus.REG_A;
        b_q  <= b_sel;
      end
      assert (!(fifo_push && fifo_full && !pop));
      assert (fifo_count <= cnt_q);
    end
  end

  assign res    = alu_compute(op_q, MAX_W'(a_q), MAX_W'(b_q), DATA_WIDTH);
  assign s1_ent = {res.carry, DATA_WIDTH'(res.data)};

  // Stages 2..PIPE_DEPTH only delay result and valid.
  if (PIPE_DEPTH == 1) begin : g_direct
    assign fifo_push  = v1_q;
    assign fifo_wdata = s1_ent;
  end else begin : g_delay
    logic [EW-1:0]         dly_q [PIPE_DEPTH-1];
    logic [PIPE_DEPTH-2:0] dv_q;

    always_ff @(posedge CLK) begin
      if (!RST) begin
        dv_q <= '0;
        for (int unsigned i = 0; i < PIPE_DEPTH - 1; i++) dly_q[i] <= '0;
      end else begin
        dv_q[0]  <= v1_q;
        dly_q[0] <= s1_ent;
        for (int unsigned i = 1; i < PIPE_DEPTH - 1; i++) begin
          dv_q[i]  <= dv_q[i-1];
          dly_q[i] <= dly_q[i-1];
        end
      end
    end

    assign fifo_push  = dv_q[PIPE_DEPTH-2];
    assign fifo_wdata = dly_q[PIPE_DEPTH-2];
  end

  alu_pipe_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.ALU_RDY    = rdy_q;
  assign bus.EX_ALU     = fifo_rdata[DATA_WIDTH-1:0];
  assign bus.EX_ALU_C   = fifo_rdata[DATA_WIDTH];
  assign bus.EX_ALU_VLD = !fifo_empty;

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized bench for alu_pipe with an integer-arithmetic reference model
// and an in-order scoreboard fed by a negedge monitor.
module tb_alu_pipe;
  localparam int unsigned DW = 8;
  localparam int unsigned PD = 2;
  localparam int unsigned FD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_pipe_if #(.DATA_WIDTH(DW)) bus ();

  alu_pipe #(.DATA_WIDTH(DW), .PIPE_DEPTH(PD), .FIFO_DEPTH(FD)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;
  int n_pop    = 0;
  logic [DW:0] exp_q[$];
  logic [DW:0] exp_done[$];
  logic [DW:0] obs_q[$];

  // Reference: plain integer arithmetic on 0..255 values, {carry, data}.
  function automatic logic [DW:0] model(int op, int a, int b);
    int d;
    bit c;
    c = 1'b0;
    case (op)
      0:  begin d = (a + b) % 256;       c = (a + b) > 255; end
      1:  begin d = (a - b + 256) % 256; c = a < b; end
      2:  begin d = (a * b) % 256;       c = (a * b) > 255; end
      3:  begin d = a / 2;               c = (a % 2) == 1; end
      4:  begin d = (a * 2) % 256;       c = a >= 128; end
      5:  d = a / 2 + (a % 2) * 128;
      6:  d = (a * 2) % 256 + a / 128;
      7:  d = 255 - a;
      8:  d = a & b;
      9:  d = a | b;
      10: d = a ^ b;
      11: d = 255 - (a & b);
      12: d = 255 - (a | b);
      13: d = 255 - (a ^ b);
      14: begin d = (a + 1) % 256;       c = a == 255; end
      default: begin d = (a + 255) % 256; c = a == 0; end
    endcase
    return {c, DW'(d)};
  endfunction

  function automatic int sel_b();
    if (bus.MOVI == 2'd0) return int'(bus.REG_B);
    if (bus.MOVI == 2'd1) return int'(bus.MEM);
    return int'(bus.IMM);
  endfunction

  // Inputs change 1 time unit after posedge, so negedge sees what the next edge samples.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.EX_ALU_VLD && bus.OUT_RDY) begin
        obs_q.push_back({bus.EX_ALU_C, bus.EX_ALU});
        exp_done.push_back(exp_q.size() > 0 ? exp_q.pop_front() : 'x);
        n_pop++;
      end
      if (bus.ACT && bus.ALU_RDY) begin
        exp_q.push_back(model(int'(bus.OP), int'(bus.REG_A), sel_b()));
        n_acc++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req();
    bus.OP    = 4'($urandom_range(0, 15));
    bus.MOVI  = 2'($urandom_range(0, 3));
    bus.REG_A = DW'($urandom);
    bus.REG_B = DW'($urandom);
    bus.MEM   = DW'($urandom);
    bus.IMM   = DW'($urandom);
  endtask

  task automatic clear_sb();
    obs_q.delete();
    exp_done.delete();
  endtask

  task automatic drain(int want, int bound);
    bus.ACT     = 1'b0;
    bus.OUT_RDY = 1'b1;
    for (int i = 0; i < bound && obs_q.size() < want; i++) tick();
  endtask

  task automatic test_reset();
    rand_req();
    bus.ACT = 1'b1; bus.OUT_RDY = 1'b1; rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus.ALU_RDY !== 1'b0) $display("FAIL reset_rdy: got %b want 0", bus.ALU_RDY); else n_pass++;
    n_checks++; if (bus.EX_ALU_VLD !== 1'b0) $display("FAIL reset_vld: got %b want 0", bus.EX_ALU_VLD); else n_pass++;
    n_checks++; if (bus.EX_ALU !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.EX_ALU); else n_pass++;
    n_checks++; if (bus.EX_ALU_C !== 1'b0) $display("FAIL reset_carry: got %b want 0", bus.EX_ALU_C); else n_pass++;
    rst_n = 1'b1; bus.ACT = 1'b0;
    n_checks++; if (bus.ALU_RDY !== 1'b0) $display("FAIL release_rdy_early: got %b want 0", bus.ALU_RDY); else n_pass++;
    tick();
    n_checks++; if (bus.ALU_RDY !== 1'b1) $display("FAIL release_rdy: got %b want 1", bus.ALU_RDY); else n_pass++;
  endtask

  task automatic test_add();
    clear_sb();
    bus.OP = 4'd0; bus.REG_A = 8'hF0; bus.REG_B = 8'h20; bus.MOVI = 2'd0;
    bus.OUT_RDY = 1'b1; bus.ACT = 1'b1;
    tick();
    bus.ACT = 1'b0;
    tick();
    n_checks++; if (bus.EX_ALU_VLD !== 1'b0) $display("FAIL add_vld_early: got %b want 0", bus.EX_ALU_VLD); else n_pass++;
    tick();
    n_checks++; if (bus.EX_ALU_VLD !== 1'b1) $display("FAIL add_vld: got %b want 1", bus.EX_ALU_VLD); else n_pass++;
    n_checks++; if (bus.EX_ALU !== 8'h10) $display("FAIL add_data: got %h want 10", bus.EX_ALU); else n_pass++;
    n_checks++; if (bus.EX_ALU_C !== 1'b1) $display("FAIL add_carry: got %b want 1", bus.EX_ALU_C); else n_pass++;
    drain(1, 10);
  endtask

  task automatic test_back_to_back();
    logic [DW:0] want [3];
    want[0] = {1'b1, 8'hFF}; want[1] = {1'b1, 8'h00}; want[2] = {1'b0, 8'h03};
    clear_sb();
    bus.OUT_RDY = 1'b1; bus.ACT = 1'b1;
    bus.OP = 4'd1; bus.REG_A = 8'h05; bus.IMM = 8'h06; bus.MOVI = 2'd2;
    tick();
    bus.OP = 4'd2; bus.REG_A = 8'h10; bus.MEM = 8'h10; bus.MOVI = 2'd1;
    tick();
    bus.OP = 4'd6; bus.REG_A = 8'h81; bus.MOVI = 2'd0;
    tick();
    bus.ACT = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.EX_ALU_VLD !== 1'b1 || {bus.EX_ALU_C, bus.EX_ALU} !== want[i])
        $display("FAIL b2b_%0d: got vld=%b c/data=%h want vld=1 c/data=%h", i, bus.EX_ALU_VLD, {bus.EX_ALU_C, bus.EX_ALU}, want[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic rdy;
    clear_sb();
    n_acc = 0;
    bus.OUT_RDY = 1'b0; bus.ACT = 1'b1;
    rand_req();
    for (int i = 0; i < 10; i++) begin
      rdy = bus.ALU_RDY;
      tick();
      if (rdy) rand_req();
    end
    n_checks++; if (n_acc !== 4) $display("FAIL bp_accepts: got %0d want 4", n_acc); else n_pass++;
    n_checks++; if (bus.ALU_RDY !== 1'b0) $display("FAIL bp_rdy_low: got %b want 0", bus.ALU_RDY); else n_pass++;
    n_checks++; if (bus.EX_ALU_VLD !== 1'b1) $display("FAIL bp_vld: got %b want 1", bus.EX_ALU_VLD); else n_pass++;
    drain(4, 20);
    n_checks++; if (obs_q.size() !== 4) $display("FAIL bp_pops: got %0d want 4", obs_q.size()); else n_pass++;
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_done[i]) $display("FAIL bp_order_%0d: got %h want %h", i, obs_q[i], exp_done[i]);
      else n_pass++;
    end
    n_checks++; if (bus.ALU_RDY !== 1'b1) $display("FAIL bp_rdy_back: got %b want 1", bus.ALU_RDY); else n_pass++;
  endtask

  task automatic test_full_stream();
    logic rdy;
    int   bad_rdy;
    clear_sb();
    bus.OUT_RDY = 1'b0; bus.ACT = 1'b1;
    rand_req();
    for (int i = 0; i < 20 && bus.ALU_RDY; i++) begin
      rdy = bus.ALU_RDY;
      tick();
      if (rdy) rand_req();
    end
    repeat (3) tick();
    bus.OUT_RDY = 1'b1;
    n_acc = 0; n_pop = 0; bad_rdy = 0;
    for (int i = 0; i < 12; i++) begin
      rdy = bus.ALU_RDY;
      tick();
      if (rdy) rand_req();
      n_checks++;
      if (bus.ALU_RDY !== 1'b1) $display("FAIL stream_rdy_%0d: got %b want 1", i, bus.ALU_RDY);
      else n_pass++;
    end
    n_checks++; if (n_acc !== 11) $display("FAIL stream_accepts: got %0d want 11", n_acc); else n_pass++;
    n_checks++; if (n_pop !== 12) $display("FAIL stream_pops: got %0d want 12", n_pop); else n_pass++;
    drain(15, 30);
    n_checks++; if (obs_q.size() !== 15) $display("FAIL stream_total: got %0d want 15", obs_q.size()); else n_pass++;
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_done[i]) $display("FAIL stream_order_%0d: got %h want %h", i, obs_q[i], exp_done[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    clear_sb();
    bus.OUT_RDY = 1'b0; bus.ACT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_req();
      tick();
    end
    n_checks++; if (bus.EX_ALU_VLD !== 1'b1) $display("FAIL rmid_pre_vld: got %b want 1", bus.EX_ALU_VLD); else n_pass++;
    rst_n = 1'b0;
    tick();
    n_checks++; if (bus.EX_ALU_VLD !== 1'b0) $display("FAIL rmid_vld: got %b want 0", bus.EX_ALU_VLD); else n_pass++;
    n_checks++; if (bus.EX_ALU !== 8'h00) $display("FAIL rmid_data: got %h want 00", bus.EX_ALU); else n_pass++;
    n_checks++; if (bus.ALU_RDY !== 1'b0) $display("FAIL rmid_rdy: got %b want 0", bus.ALU_RDY); else n_pass++;
    rst_n = 1'b1; bus.ACT = 1'b0; bus.OUT_RDY = 1'b1;
    clear_sb();
    repeat (8) tick();
    n_checks++; if (obs_q.size() !== 0) $display("FAIL rmid_stale: got %0d results want 0", obs_q.size()); else n_pass++;
  endtask

  task automatic test_random();
    logic rdy;
    bit   taken;
    int   total;
    clear_sb();
    total = 52;
    for (int k = 0; k < total; k++) begin
      rand_req();
      bus.OP   = 4'(k % 16);
      bus.MOVI = (k < 48) ? 2'(k / 16) : 2'd3;
      bus.ACT  = 1'b1;
      taken    = 1'b0;
      for (int t = 0; t < 40 && !taken; t++) begin
        rdy = bus.ALU_RDY;
        tick();
        bus.OUT_RDY = ($urandom_range(0, 3) != 0);
        taken = rdy;
      end
      bus.ACT = 1'b0;
      if (!taken) begin
        n_checks++;
        $display("FAIL rand_accept_%0d: got no accept want accept within 40 cycles", k);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end
    drain(total, 60);
    n_checks++; if (obs_q.size() !== total) $display("FAIL rand_total: got %0d want %0d", obs_q.size(), total); else n_pass++;
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_done[i]) $display("FAIL rand_result_%0d: got %h want %h", i, obs_q[i], exp_done[i]);
      else n_pass++;
    end
  endtask

  initial begin
    bus.ACT = 1'b0; bus.OUT_RDY = 1'b0;
    bus.OP = '0; bus.MOVI = '0; bus.REG_A = '0; bus.REG_B = '0; bus.MEM = '0; bus.IMM = '0;
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_full_stream();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
